// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM state encoding and request decode helpers for the LSU.
package lsu_pkg;

    localparam int unsigned XLEN = 32;

    // RV32I load widths
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // RV32I store widths
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    // True when funct3 is a defined code for the given direction.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        if (we) ok = (f3 == SB) || (f3 == SH) || (f3 == SW);
        else    ok = (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
        return ok;
    endfunction

    // True when the byte offset breaks natural alignment for the access width.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        case (f3[1:0])
            2'b01:   bad = off[0];
            2'b10:   bad = (off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Byte offset rounded down to the natural alignment of the access width.
    function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
        logic [1:0] o;
        case (f3[1:0])
            2'b01:   o = {off[1], 1'b0};
            2'b10:   o = 2'b00;
            default: o = off;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane select and extension for loads, byte/halfword merge for sub-word stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane out of the memory word and extend it.
    always_comb begin
        case (off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
            LH:      load_data = {{16{half_sel[15]}}, half_sel};
            LW:      load_data = rdata;
            LBU:     load_data = {24'd0, byte_sel};
            LHU:     load_data = {16'd0, half_sel};
            default: load_data = '0;
        endcase
    end

    // Replace only the addressed byte/halfword of the old word.
    always_comb begin
        store_word = rdata;
        case (funct3)
            SB: begin
                case (off)
                    2'd0:    store_word[7:0]   = wdata[7:0];
                    2'd1:    store_word[15:8]  = wdata[7:0];
                    2'd2:    store_word[23:16] = wdata[7:0];
                    default: store_word[31:24] = wdata[7:0];
                endcase
            end
            SH: begin
                if (off[1]) store_word[31:16] = wdata;
                else        store_word[15:0]  = wdata;
            end
            default: store_word = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one request at a time against a word-wide memory.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;
    logic        mem_write_q;
    logic        req_fault;
    logic [31:0] load_data;
    logic [31:0] store_word;

    // Request decode and handshake; the write strobe is killed during reset.
    assign req_ready = (state == IDLE) && !rst;
    assign mem_write = mem_write_q && !rst;
    assign req_fault = !f3_legal(req_we, req_funct3)
                     || (ALIGN_CHECK && misaligned(req_funct3, req_addr[1:0]));

    lsu_align u_align (
        .funct3     (f3_q),
        .off        (off_q),
        .rdata      (mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Sequencer: IDLE -> {READ} -> {WRITE} -> RESP, all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            mem_read    <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            we_q        <= 1'b0;
            f3_q        <= '0;
            off_q       <= '0;
            wdata_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        off_q   <= align_off(req_funct3, req_addr[1:0]);
                        wdata_q <= req_wdata[15:0];
                        if (req_fault) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_we && (req_funct3 == SW)) begin
                            state       <= WRITE;
                            mem_write_q <= 1'b1;
                            mem_addr    <= {req_addr[31:2], 2'b00};
                            mem_wdata   <= req_wdata;
                        end else begin
                            state    <= READ;
                            mem_read <= 1'b1;
                            mem_addr <= {req_addr[31:2], 2'b00};
                        end
                    end
                end
                READ: begin
                    mem_read <= 1'b0;
                    if (we_q) begin
                        state       <= WRITE;
                        mem_write_q <= 1'b1;
                        mem_wdata   <= store_word;
                    end else begin
                        state      <= RESP;
                        mem_addr   <= '0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_data;
                    end
                end
                WRITE: begin
                    state       <= RESP;
                    mem_write_q <= 1'b0;
                    mem_addr    <= '0;
                    mem_wdata   <= '0;
                    resp_valid  <= 1'b1;
                    resp_err    <= 1'b0;
                    resp_rdata  <= '0;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench: two lsu_ctrl instances (ALIGN_CHECK 1 and 0) share one request stream.
module tb_lsu_ctrl;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  lat;
        logic [3:0]  rd;
        logic [3:0]  wr;
        logic [31:0] addr;
        logic [31:0] wval;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, req_we, resp_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rdy [2];
    logic        rv [2];
    logic        rerr [2];
    logic        mrd [2];
    logic        mwr [2];
    logic [31:0] rdat [2];
    logic [31:0] maddr [2];
    logic [31:0] mwd [2];
    logic [31:0] mrdat [2];
    logic [31:0] mem [2][64];
    logic [31:0] ref_mem [2][64];

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q0 [$];
    exp_t exp_q1 [$];

    bit          active [2];
    bit          seen [2];
    int          cyc [2];
    int          rdc [2];
    int          wrc [2];
    int          vcnt [2];
    int          last_vcnt [2];
    logic [31:0] la [2];
    logic [31:0] lw [2];
    logic [31:0] s_rdata [2];
    logic        s_err [2];
    logic [31:0] last_rdata [2];
    logic        last_err [2];
    int          cycle_n = 0;
    int          hold_until = 0;
    bit          aborted = 0;

    lsu_ctrl #(.ALIGN_CHECK(1'b1)) u_dut_chk (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv[0]), .resp_ready(resp_ready), .resp_rdata(rdat[0]), .resp_err(rerr[0]),
        .mem_read(mrd[0]), .mem_write(mwr[0]), .mem_addr(maddr[0]), .mem_wdata(mwd[0]),
        .mem_rdata(mrdat[0])
    );

    lsu_ctrl #(.ALIGN_CHECK(1'b0)) u_dut_noc (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv[1]), .resp_ready(resp_ready), .resp_rdata(rdat[1]), .resp_err(rerr[1]),
        .mem_read(mrd[1]), .mem_write(mwr[1]), .mem_addr(maddr[1]), .mem_wdata(mwd[1]),
        .mem_rdata(mrdat[1])
    );

    assign mrdat[0] = mem[0][maddr[0][7:2]];
    assign mrdat[1] = mem[1][maddr[1][7:2]];

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h8001_7F80;
        if (i == 8) return 32'h1122_3344;
        return (32'h9E37_79B9 * 32'(i + 1)) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %h expected %h", name, g, act, exp);
        end
    endtask

    // Word memories behind each DUT.
    initial begin
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 64; i++)
                mem[g][i] <= init_word(i);
        forever begin
            @(posedge clk);
            for (int g = 0; g < 2; g++)
                if (mwr[g]) mem[g][maddr[g][7:2]] <= mwd[g];
        end
    end

    // Response back-pressure: random, with an optional forced stall window.
    initial begin
        resp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cycle_n++;
            if (cycle_n < hold_until) resp_ready = 1'b0;
            else                      resp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Reference model: RV32I load/store semantics on a shadow word array.
    task automatic predict(input int g, input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        bit          legal, mis;
        logic [1:0]  size, off;
        int          idx;
        logic [31:0] word, v, mask, newv;
        e     = '0;
        size  = f3[1:0];
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis   = (g == 0) && ((size == 2'd1 && a[0]) || (size == 2'd2 && a[1:0] != 2'b00));
        if (!legal || mis) begin
            e.err = 1'b1;
            e.lat = 4'd1;
        end else begin
            off    = (size == 2'd0) ? a[1:0] : (size == 2'd1) ? {a[1], 1'b0} : 2'd0;
            idx    = int'(a[7:2]);
            word   = ref_mem[g][idx];
            e.addr = {a[31:2], 2'b00};
            if (!we) begin
                v = word >> (8 * off);
                if (size == 2'd0) begin
                    v = v & 32'hFF;
                    if (!f3[2] && v >= 32'd128) v = v - 32'd256;
                end else if (size == 2'd1) begin
                    v = v & 32'hFFFF;
                    if (!f3[2] && v >= 32'd32768) v = v - 32'd65536;
                end
                e.rdata = v;
                e.lat   = 4'd2;
                e.rd    = 4'd1;
            end else begin
                if (size == 2'd2) begin
                    newv  = wd;
                    e.lat = 4'd2;
                end else begin
                    mask  = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
                    newv  = (word & ~mask) | ((wd << (8 * off)) & mask);
                    e.lat = 4'd3;
                    e.rd  = 4'd1;
                end
                e.wr   = 4'd1;
                e.wval = newv;
                ref_mem[g][idx] = newv;
            end
        end
        if (g == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    // Monitor for one instance, sampled on the falling edge.
    task automatic mon(input int g);
        exp_t e;
        bit   empty;
        if (rst) begin
            active[g] = 0; seen[g] = 0; rdc[g] = 0; wrc[g] = 0; vcnt[g] = 0;
            return;
        end
        chk("rd_wr_exclusive", g, 32'(mrd[g] & mwr[g]), 32'd0);
        if (mrd[g] || mwr[g]) begin
            if (mrd[g]) rdc[g]++;
            if (mwr[g]) begin wrc[g]++; lw[g] = mwd[g]; end
            la[g] = maddr[g];
        end else begin
            chk("mem_idle_addr", g, maddr[g], 32'd0);
            chk("mem_idle_wdata", g, mwd[g], 32'd0);
        end
        if (active[g]) cyc[g]++;
        if (rv[g]) begin
            vcnt[g]++;
            chk("req_ready_in_resp", g, 32'(rdy[g]), 32'd0);
            if (!seen[g]) begin
                empty = (g == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
                if (empty) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_resp inst%0d: got resp_valid=1 expected no response", g);
                end else begin
                    e = (g == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    chk("resp_rdata", g, rdat[g], e.rdata);
                    chk("resp_err", g, 32'(rerr[g]), 32'(e.err));
                    chk("latency", g, 32'(cyc[g]), 32'(e.lat));
                    chk("read_cycles", g, 32'(rdc[g]), 32'(e.rd));
                    chk("write_cycles", g, 32'(wrc[g]), 32'(e.wr));
                    if (e.rd != 0 || e.wr != 0) chk("mem_addr", g, la[g], e.addr);
                    if (e.wr != 0) chk("mem_wdata", g, lw[g], e.wval);
                end
                seen[g] = 1; s_rdata[g] = rdat[g]; s_err[g] = rerr[g];
                last_rdata[g] = rdat[g]; last_err[g] = rerr[g];
            end else begin
                chk("resp_rdata_stable", g, rdat[g], s_rdata[g]);
                chk("resp_err_stable", g, 32'(rerr[g]), 32'(s_err[g]));
            end
        end
        if (req_valid && rdy[g]) begin
            active[g] = 1; cyc[g] = 0; rdc[g] = 0; wrc[g] = 0; vcnt[g] = 0;
        end
        if (rv[g] && resp_ready) begin
            seen[g] = 0; active[g] = 0; last_vcnt[g] = vcnt[g];
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(posedge clk);
            #1;
            done = rdy[0] && rdy[1] && exp_q0.size() == 0 && exp_q1.size() == 0;
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL idle_timeout: got busy after 80 cycles expected idle");
            aborted = 1;
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        predict(0, we, f3, a, wd);
        predict(1, we, f3, a, wd);
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 64; i++)
                ref_mem[g][i] = init_word(i);
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            chk("reset_resp_valid", g, 32'(rv[g]), 32'd0);
            chk("reset_resp_rdata", g, rdat[g], 32'd0);
            chk("reset_resp_err", g, 32'(rerr[g]), 32'd0);
            chk("reset_req_ready", g, 32'(rdy[g]), 32'd0);
            chk("reset_mem_en", g, 32'({mrd[g], mwr[g]}), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Sign/zero extension on a known word.
        issue(1'b0, 3'b000, 32'h10, 32'h0);
        for (int g = 0; g < 2; g++) chk("lb_0x10", g, last_rdata[g], 32'hFFFF_FF80);
        issue(1'b0, 3'b100, 32'h11, 32'h0);
        for (int g = 0; g < 2; g++) chk("lbu_0x11", g, last_rdata[g], 32'h0000_007F);
        issue(1'b0, 3'b001, 32'h12, 32'h0);
        for (int g = 0; g < 2; g++) chk("lh_0x12", g, last_rdata[g], 32'hFFFF_8001);

        // Byte store read-modify-write, then read back.
        issue(1'b1, 3'b000, 32'h21, 32'h0000_00AB);
        for (int g = 0; g < 2; g++) chk("sb_merge", g, lw[g], 32'h1122_AB44);
        issue(1'b0, 3'b010, 32'h20, 32'h0);
        for (int g = 0; g < 2; g++) chk("lw_after_sb", g, last_rdata[g], 32'h1122_AB44);

        // Misaligned word load: faults when checked, aligns down otherwise.
        issue(1'b0, 3'b010, 32'h06, 32'h0);
        chk("lw_mis_err", 0, 32'(last_err[0]), 32'd1);
        chk("lw_mis_rdata", 0, last_rdata[0], 32'd0);
        chk("lw_mis_noc_err", 1, 32'(last_err[1]), 32'd0);
        chk("lw_mis_noc_rdata", 1, last_rdata[1], init_word(1));

        // Illegal store code with a long response stall.
        hold_until = cycle_n + 7;
        issue(1'b1, 3'b011, 32'h40, 32'hDEAD_BEEF);
        for (int g = 0; g < 2; g++) begin
            chk("illegal_err", g, 32'(last_err[g]), 32'd1);
            chk("stall_hold_ge5", g, 32'(last_vcnt[g] >= 5), 32'd1);
        end

        // Reset landing on the write cycle of a halfword store.
        req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h32; req_wdata = 32'h0000_5A5A;
        req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 2; g++) chk("rst_write_gated", g, 32'(mwr[g]), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_req_ready", g, 32'(rdy[g]), 32'd1);
            chk("rst_no_resp", g, 32'(rv[g]), 32'd0);
            chk("rst_mem_unchanged", g, mem[g][12], ref_mem[g][12]);
        end
        @(posedge clk); #1;

        // Randomized traffic, including illegal codes and misaligned addresses.
        for (int n = 0; n < 300 && !aborted; n++)
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);

        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 64; i++)
                chk("mem_final", g, mem[g][i], ref_mem[g][i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish within 1ms");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter ALIGN_CHECK, default 1, meaning 1 = misaligned requests are faulted and 0 = addr[1:0] is forced to the natural alignment (a silently aligned access).
REQ-002 SHALL have a single clock `clk`; reset `rst` is synchronous and active-high.
REQ-003 Ports, in order:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  CPU request present
- req_ready  out  1  lsu_ctrl can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code
- req_addr  in  32  byte address
- req_wdata  in  32  store data (rs2)
- resp_valid  out  1  result/completion present
- resp_ready  in  1  CPU consumes the response
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_err  out  1  misaligned access or illegal funct3
- mem_read  out  1  word-memory read enable
- mem_write  out  1  word-memory write enable
- mem_addr  out  32  word-aligned byte address, bits [1:0] = 00
- mem_wdata  out  32  word to store
- mem_rdata  in  32  combinational read data from the word memory

Function
REQ-004 The FSM SHALL have the states IDLE, READ, WRITE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-005 A request SHALL be accepted on a clk edge with req_valid&req_ready; req_we, funct3, addr and wdata SHALL be registered at that edge.
REQ-006 Legal loads SHALL be funct3 000 LB, 001 LH, 010 LW, 100 LBU and 101 LHU; legal stores SHALL be 000 SB, 001 SH and 010 SW; any other code SHALL be illegal.
REQ-007 Faults (illegal funct3, or with ALIGN_CHECK=1 an LH/LHU/SH with addr[0]=1 or an LW/SW with addr[1:0]!=00) SHALL go IDLE->RESP with resp_err=1 and no mem_read/mem_write pulse.
REQ-008 A load SHALL go IDLE->READ->RESP; in READ, mem_read=1 and mem_addr={addr[31:2],2'b00}, and the selected lane of mem_rdata SHALL be extended and registered at the end of READ.
REQ-009 Load extension: LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend; the byte lane is addr[1:0] and the halfword lane is addr[1].
REQ-010 SW SHALL go IDLE->WRITE->RESP with mem_write=1 for exactly one cycle and mem_wdata=req_wdata.
REQ-011 SB/SH SHALL go IDLE->READ->WRITE->RESP (read-modify-write): the old word is captured in READ and only the addressed byte/halfword is replaced from req_wdata[7:0]/[15:0].
REQ-012 In RESP, resp_valid=1 and SHALL hold with stable data until resp_ready=1; the transition to IDLE SHALL occur on the edge where resp_ready=1.
REQ-013 Latency from acceptance edge to first resp_valid cycle SHALL be: load 2, SW 2, SB/SH 3, fault 1.
REQ-014 mem_read, mem_write, mem_addr and mem_wdata SHALL be 0 outside READ/WRITE.
REQ-015 mem_read and mem_write SHALL never be high in the same cycle.
REQ-016 With ALIGN_CHECK=0, misaligned addresses SHALL be aligned down (LH/SH: addr[0] ignored; LW/SW: addr[1:0] ignored) and resp_err SHALL reflect only illegal funct3.
REQ-017 Address bits [31:2] SHALL pass through unmodified; wrap-around and range checking are the memory's concern.

Reset
REQ-018 On a clk edge with rst=1, the FSM SHALL go to IDLE and all registered outputs SHALL clear: resp_valid=0, resp_rdata=0, resp_err=0.
REQ-019 mem_write SHALL be gated combinationally by !rst, so a WRITE cycle coinciding with rst=1 does not modify memory; an in-flight request SHALL be dropped with no response.
REQ-020 req_ready SHALL be 0 while rst=1.

Structure
REQ-021 A shared package lsu_pkg SHALL hold the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the state encoding.
REQ-022 One sub-module, lsu_align, SHALL hold the combinational lane select/extension for loads and the byte/halfword merge for stores; the FSM stays in lsu_ctrl.

Verification
REQ-023 Memory word 0x10 = 0x8001_7F80; LB at 0x10 -> resp_rdata=0xFFFF_FF80; LBU at 0x11 -> 0x0000_007F; LH at 0x12 -> 0xFFFF_8001; each with resp_valid 2 cycles after acceptance.
REQ-024 Word 0x20 = 0x1122_3344; SB 0xAB at 0x21 -> exactly one READ then one mem_write with mem_wdata=0x1122_AB44; a later LW reads 0x1122_AB44.
REQ-025 LW at 0x06 with ALIGN_CHECK=1 -> resp_err=1, resp_rdata=0, zero memory enables, resp_valid 1 cycle after acceptance; the same access with ALIGN_CHECK=0 reads the word at 0x04.
REQ-026 Illegal funct3 011 as a store -> resp_err=1 and no mem_write; resp_ready held 0 for 5 cycles -> resp_valid and data stable and req_ready=0 throughout.
REQ-027 rst asserted during the WRITE cycle of an SH -> memory unchanged, next cycle IDLE with req_ready=1 and no resp_valid.
